// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor with carry-in and valid/ready handshake.
// Each stage ripples one CHUNK-bit segment. Unprocessed operands and partial sums skew forward.
module pipelined_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             v_o,
  output logic             z_o
);

  localparam int unsigned STAGES = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("pipelined_add_sub: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] be_q  [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             cy_q  [STAGES];
  logic             v_q;
  logic             z_q;
  logic             advance;

  // The whole pipe moves as one; bubbles are shifted, never squeezed out.
  assign advance = !vld_q[LAST] || ready_i;
  assign ready_o = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] be_in;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] s_nxt;
    logic             c_in;
    logic             vld_in;
    logic [CHUNK:0]   sum;

    if (k == 0) begin : g_head
      // Subtract as a + ~b + ~borrow so one adder serves both operations.
      assign a_in   = a_i;
      assign be_in  = sub_i ? ~b_i : b_i;
      assign c_in   = sub_i ^ c_i;
      assign s_in   = '0;
      assign vld_in = valid_i;
    end else begin : g_body
      assign a_in   = a_q[k-1];
      assign be_in  = be_q[k-1];
      assign c_in   = cy_q[k-1];
      assign s_in   = s_q[k-1];
      assign vld_in = vld_q[k-1];
    end

    always_comb begin
      sum   = {1'b0, a_in[k*CHUNK +: CHUNK]} + {1'b0, be_in[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_in};
      s_nxt = s_in;
      s_nxt[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        be_q[k]  <= '0;
        s_q[k]   <= '0;
        cy_q[k]  <= 1'b0;
      end else if (advance) begin
        vld_q[k] <= vld_in;
        if (vld_in) begin
          a_q[k]  <= a_in;
          be_q[k] <= be_in;
          s_q[k]  <= s_nxt;
          cy_q[k] <= sum[CHUNK];
        end
      end
    end

    if (k == LAST) begin : g_flags
      logic v_nxt;
      // Equal operand signs with a differing result sign is the MSB carry-in/out mismatch.
      assign v_nxt = (a_in[WIDTH-1] ~^ be_in[WIDTH-1]) & (s_nxt[WIDTH-1] ^ a_in[WIDTH-1]);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v_q <= 1'b0;
          z_q <= 1'b0;
        end else if (advance && vld_in) begin
          v_q <= v_nxt;
          z_q <= (s_nxt == '0);
        end
      end
    end
  end

  assign valid_o = vld_q[LAST];
  assign s_o     = s_q[LAST];
  assign c_o     = cy_q[LAST];
  assign v_o     = v_q;
  assign z_o     = z_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub at WIDTH=8, CHUNK=4 (two stages).
module tb_pipelined_add_sub;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       z;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] s_o;
  logic       c_o;
  logic       v_o;
  logic       z_o;

  int   tests     = 0;
  int   fails     = 0;
  int   n_results = 0;
  res_t sb_q[$];
  res_t exp_r;
  res_t got_r;

  pipelined_add_sub #(
    .WIDTH(8),
    .CHUNK(4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .a_i    (a),
    .b_i    (b),
    .c_i    (cin),
    .sub_i  (sub),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .s_o    (s_o),
    .c_o    (c_o),
    .v_o    (v_o),
    .z_o    (z_o)
  );

  always #5 clk = ~clk;

  // Reference arithmetic on plain integers, independent of any adder structure.
  function automatic res_t model(input logic [7:0] av, input logic [7:0] bv,
                                 input logic cv, input logic subv);
    res_t m;
    int   ua = av;
    int   ub = bv;
    int   uc = cv;
    int   sa = $signed(av);
    int   sb = $signed(bv);
    int   r;
    int   sr;
    if (!subv) begin
      r   = ua + ub + uc;
      sr  = sa + sb + uc;
      m.c = (r > 255);
    end else begin
      r   = ua - ub - uc;
      sr  = sa - sb - uc;
      m.c = (r >= 0);
    end
    m.s = r[7:0];
    m.v = (sr > 127) || (sr < -128);
    m.z = (m.s == 8'h00);
    return m;
  endfunction

  // Output consumed on the next edge when valid_o && ready_i; input accepted when valid_i && ready_o.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o && ready_i) begin
        tests++;
        got_r = '{s: s_o, c: c_o, v: v_o, z: z_o};
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got s=%h c=%b v=%b z=%b, required no output",
                   s_o, c_o, v_o, z_o);
        end else begin
          exp_r = sb_q.pop_front();
          n_results++;
          if (got_r !== exp_r)
            begin
              fails++;
              $display("FAIL sb_result: got s=%h c=%b v=%b z=%b, required s=%h c=%b v=%b z=%b",
                       got_r.s, got_r.c, got_r.v, got_r.z, exp_r.s, exp_r.c, exp_r.v, exp_r.z);
            end
        end
      end
      if (valid_i && ready_o) sb_q.push_back(model(a, b, cin, sub));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Presents one beat and returns 1 time unit after the edge that accepts it.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic subv);
    int n = 0;
    a = av; b = bv; cin = cv; sub = subv; valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ready_o) begin
      tests++; fails++;
      $display("FAIL send_timeout: ready_o=%b, required 1 within 50 cycles", ready_o);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || valid_o) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0 || valid_o) begin
      tests++; fails++;
      $display("FAIL drain_timeout: pending=%0d valid_o=%b, required 0 and 0",
               sb_q.size(), valid_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2;
    tests++;
    if ({valid_o, s_o, c_o, v_o, z_o} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b s=%h c=%b v=%b z=%b, required all 0",
               valid_o, s_o, c_o, v_o, z_o);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got ready_o=%b valid_o=%b, required 1 and 0",
               ready_o, valid_o);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'h7F, 8'hFF, 8'h00, 8'h80};
    logic [7:0] tb [4] = '{8'h01, 8'h00, 8'h01, 8'h01};
    logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    res_t       te [4] = '{'{8'h80, 1'b0, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b0, 1'b1},
                           '{8'hFF, 1'b0, 1'b0, 1'b0}, '{8'h7F, 1'b1, 1'b1, 1'b0}};
    res_t       g;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb[i], tc[i], ts[i]);
      tests++;
      if (valid_o !== 1'b0) begin
        fails++;
        $display("FAIL directed_latency[%0d]: valid_o=%b one cycle after accept, required 0",
                 i, valid_o);
      end
      @(posedge clk);
      #1;
      g = '{s: s_o, c: c_o, v: v_o, z: z_o};
      tests++;
      if (valid_o !== 1'b1 || g !== te[i]) begin
        fails++;
        $display("FAIL directed[%0d]: got valid=%b s=%h c=%b v=%b z=%b, required 1 %h %b %b %b",
                 i, valid_o, g.s, g.c, g.v, g.z, te[i].s, te[i].c, te[i].v, te[i].z);
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int start = n_results;
    ready_i = 1'b1;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(8'(i), 8'(i), 1'b0, 1'b0);
      end
      begin
        int n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!valid_o && n < 20);
        ready_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          tests++;
          if (ready_o !== 1'b0 || valid_o !== 1'b1 || s_o !== 8'h02) begin
            fails++;
            $display("FAIL stall_hold[%0d]: got ready_o=%b valid_o=%b s=%h, required 0 1 02",
                     j, ready_o, valid_o, s_o);
          end
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    drain();
    tests++;
    if (n_results - start !== 4) begin
      fails++;
      $display("FAIL stall_count: got %0d results, required 4", n_results - start);
    end
  endtask

  task automatic test_back_to_back();
    int  start = n_results;
    time t_first = 0;
    time t_last = 0;
    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (i == 0) t_first = $time;
      t_last = $time;
    end
    tests++;
    if (t_last - t_first !== 150) begin
      fails++;
      $display("FAIL throughput: 16 accepts spanned %0t, required 150", t_last - t_first);
    end
    drain();
    tests++;
    if (n_results - start !== 16) begin
      fails++;
      $display("FAIL throughput_count: got %0d results, required 16", n_results - start);
    end
  endtask

  task automatic test_reset_midop();
    int start;
    ready_i = 1'b1;
    send(8'h12, 8'h34, 1'b0, 1'b0);
    send(8'h56, 8'h78, 1'b1, 1'b1);
    tests++;
    if (valid_o !== 1'b1) begin
      fails++;
      $display("FAIL midop_inflight: valid_o=%b before reset, required 1", valid_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (valid_o !== 1'b0 || s_o !== 8'h00) begin
      fails++;
      $display("FAIL midop_async: got valid_o=%b s=%h, required 0 and 00", valid_o, s_o);
    end
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (valid_o !== 1'b0) begin
        fails++;
        $display("FAIL midop_stale[%0d]: valid_o=%b after release, required 0", i, valid_o);
      end
    end
    start = n_results;
    send(8'h0F, 8'h01, 1'b0, 1'b0);
    drain();
    tests++;
    if (n_results - start !== 1) begin
      fails++;
      $display("FAIL midop_resume: got %0d results, required 1", n_results - start);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor with carry-in. Next generation of the team's single-bit full adder.
- Splits a WIDTH-bit operation into CHUNK-bit ripple segments, one register stage per segment.
- Adds a valid/ready handshake with backpressure and status flags (carry, signed overflow, zero).
- Sits in the datapath between operand-issue logic and result consumers.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥1.
- CHUNK, 4, bits added per pipeline stage. WIDTH % CHUNK must be 0, otherwise elaboration fails via $error. Number of stages STAGES = WIDTH/CHUNK.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- valid_i  input  1  operand beat valid
- ready_o  output  1  block can accept a beat this cycle
- a_i  input  WIDTH  operand A
- b_i  input  WIDTH  operand B
- c_i  input  1  carry-in (add) / borrow-in (sub)
- sub_i  input  1  0 = add, 1 = subtract
- valid_o  output  1  result beat valid
- ready_i  input  1  consumer accepts result this cycle
- s_o  output  WIDTH  result
- c_o  output  1  adder carry-out of MSB
- v_o  output  1  signed overflow
- z_o  output  1  result equals zero

Behaviour:
- Reset is asynchronous, active-low: clk_i single clock, rst_ni clears all state immediately.
  - All stage valid bits, s_o, c_o, v_o and z_o are 0.
  - ready_o is 1 while out of reset.
- Arithmetic:
  - Effective B: Be = sub_i ? ~b_i : b_i. Effective carry-in: Ce = sub_i ? ~c_i : c_i.
  - Result: {c_o, s_o} = a_i + Be + Ce. Add: a+b+c. Sub: a-b-c.
  - For sub, c_o=1 means no borrow.
  - v_o = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - z_o = (s_o == 0).
- Pipeline:
  - Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] using the registered carry from stage k-1; stage 0 uses Ce.
  - Unprocessed operand chunks and completed sum chunks are carried forward in skew registers.
  - Each stage holds a valid bit.
  - Final stage registers drive the outputs directly.
- Latency: a beat accepted at edge N appears on valid_o after edge N+STAGES-1, i.e. STAGES cycles from acceptance to valid output when there is no stall.
- Handshake:
  - advance = !valid_o || ready_i; ready_o = advance.
  - Input accepted when valid_i && ready_o.
  - On advance, every stage shifts one place, bubbles included; bubbles are not compressed.
  - When advance=0, all stages hold and s_o/c_o/v_o/z_o/valid_o stay stable.
- Sampling: a_i, b_i, c_i and sub_i are sampled only on acceptance; inputs are don't-care otherwise.
- Throughput: one beat per cycle while ready_i=1.
- Boundaries:
  - STAGES=1 (CHUNK=WIDTH) gives a single-cycle registered adder.
  - Simultaneous output consume and input accept in the same cycle is legal and loses nothing.
  - Results leave in issue order.
  - Reset mid-operation discards all in-flight beats; no stale valid_o after release.
- Flags are undefined-free: computed only from stage data, and registered together with s_o.

Test Plan (WIDTH=8, CHUNK=4, STAGES=2):
- Add: a=0x7F, b=0x01, c=0, sub=0, ready_i=1 → 2 cycles later valid_o=1, s=0x80, c_o=0, v_o=1, z_o=0.
- Cross-chunk carry: a=0xFF, b=0x00, c=1, sub=0 → s=0x00, c_o=1, v_o=0, z_o=1.
- Subtract: a=0x00, b=0x01, c=0, sub=1 → s=0xFF, c_o=0 (borrow), v_o=0. Second case a=0x80, b=0x01 → s=0x7F, c_o=1, v_o=1.
- Backpressure: stream 4 back-to-back adds (i+i for i=1..4), hold ready_i=0 for 3 cycles after the first result.
  - ready_o=0 during the stall.
  - valid_o/s_o hold 0x02.
  - After release, results 0x02, 0x04, 0x06, 0x08 arrive in order with no loss or duplication.
- Full throughput: 16 random beats with ready_i=1 → 16 results, one per cycle, matching a reference model.
- Reset mid-operation: drop rst_ni with 2 beats in flight → valid_o=0 and s_o=0 immediately, without waiting for a clock edge. After release, valid_o stays 0 until a new beat is issued.
